// File: rtl/demux_1to2_buf_pkg.sv
// Shared definitions for the 1:2 buffered demultiplexer.
//   DEF_SIZE  - default data word width
//   DEF_DEPTH - default entries per output FIFO (power of two, >= 2)
//   clog2()   - constant function sizing pointers and occupancy counts
package demux_1to2_buf_pkg;

  localparam int DEF_SIZE  = 32;
  localparam int DEF_DEPTH = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_1to2_buf_fifo_sync.sv
// Synchronous FIFO used for each output channel of demux_1to2_buf.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset (pointers/count only)
//   push, wdata  - write request and word; ignored while full
//   pop          - read request; ignored while empty
//   rdata        - head-of-queue word, reads as zero while empty
//   full, empty  - occupancy flags
//   count        - occupancy, 0..depth
module fifo_sync
  import demux_1to2_buf_pkg::*;
#(
  parameter int size  = DEF_SIZE,
  parameter int depth = DEF_DEPTH,
  localparam int AW   = clog2(depth),
  localparam int CW   = AW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic            pop,
  input  logic [size-1:0] wdata,
  output logic [size-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [size-1:0] mem [depth];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is not reset; gating rdata on empty gives a zero head word after
  // reset without clearing the array.
  assign rdata = empty ? '0 : mem[rptr];

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/demux_1to2_buf.sv
// 1:2 demultiplexer with an independent FIFO per output channel, so each
// consumer can stall on its own.
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   data_i, valid_i, select_i - producer word, valid, destination (0/1)
//   ready_o                   - selected channel has room
//   data0_o, valid0_o, ready0_i, count0_o - channel 0 output and occupancy
//   data1_o, valid1_o, ready1_i, count1_o - channel 1 output and occupancy
module demux_1to2_buf
  import demux_1to2_buf_pkg::*;
#(
  parameter int size  = DEF_SIZE,
  parameter int depth = DEF_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [size-1:0]       data_i,
  input  logic                  valid_i,
  input  logic                  select_i,
  output logic                  ready_o,
  output logic [size-1:0]       data0_o,
  output logic                  valid0_o,
  input  logic                  ready0_i,
  output logic [size-1:0]       data1_o,
  output logic                  valid1_o,
  input  logic                  ready1_i,
  output logic [clog2(depth):0] count0_o,
  output logic [clog2(depth):0] count1_o
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;

  // A full channel refuses input even if it pops this cycle (no bypass).
  assign ready_o = select_i ? ~full1 : ~full0;
  assign push0   = valid_i & ~select_i & ~full0;
  assign push1   = valid_i &  select_i & ~full1;

  assign valid0_o = ~empty0;
  assign valid1_o = ~empty1;

  fifo_sync #(.size(size), .depth(depth)) u_fifo0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push0),
    .pop   (ready0_i),
    .wdata (data_i),
    .rdata (data0_o),
    .full  (full0),
    .empty (empty0),
    .count (count0_o)
  );

  fifo_sync #(.size(size), .depth(depth)) u_fifo1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push1),
    .pop   (ready1_i),
    .wdata (data_i),
    .rdata (data1_o),
    .full  (full1),
    .empty (empty1),
    .count (count1_o)
  );

endmodule

// File: tb/tb_demux_1to2_buf.sv
module tb_demux_1to2_buf;

  localparam int SIZE  = 32;
  localparam int DEPTH = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [SIZE-1:0] data_i;
  logic            valid_i;
  logic            select_i;
  logic            ready_o;
  logic [SIZE-1:0] data0_o, data1_o;
  logic            valid0_o, valid1_o;
  logic            ready0_i, ready1_i;
  logic [1:0]      count0_o, count1_o;

  demux_1to2_buf #(.size(SIZE), .depth(DEPTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .select_i (select_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .count0_o (count0_o),
    .count1_o (count1_o)
  );

  always #5 clk_i = ~clk_i;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected contents of each channel FIFO.
  logic [SIZE-1:0] q0[$];
  logic [SIZE-1:0] q1[$];
  bit armed = 0;
  bit rstf0 = 0;
  bit rstf1 = 0;

  // Checks current outputs against the model, then advances the model by the
  // handshakes that will occur at the coming rising edge.
  always @(negedge clk_i) begin
    if (armed) begin
      logic exp_rdy;
      exp_rdy = select_i ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
      chk("ready_o", ready_o, exp_rdy);
      chk("valid0", valid0_o, q0.size() != 0);
      chk("valid1", valid1_o, q1.size() != 0);
      chk("count0", count0_o, q0.size());
      chk("count1", count1_o, q1.size());
      chk("count0_le_depth", count0_o <= DEPTH, 1);
      if (q0.size() != 0) chk("data0", data0_o, q0[0]);
      else if (rstf0)     chk("data0_rst", data0_o, 0);
      if (q1.size() != 0) chk("data1", data1_o, q1[0]);
      else if (rstf1)     chk("data1_rst", data1_o, 0);

      if (rst_i) begin
        q0.delete();
        q1.delete();
        rstf0 = 1;
        rstf1 = 1;
      end else begin
        if (q0.size() != 0 && ready0_i) void'(q0.pop_front());
        if (q1.size() != 0 && ready1_i) void'(q1.pop_front());
        if (valid_i && exp_rdy) begin
          if (select_i) begin q1.push_back(data_i); rstf1 = 0; end
          else          begin q0.push_back(data_i); rstf0 = 0; end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push(input logic [SIZE-1:0] d, input logic s);
    valid_i  = 1'b1;
    data_i   = d;
    select_i = s;
    step();
    valid_i  = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; data_i = '0; valid_i = 0; select_i = 0;
    ready0_i = 0; ready1_i = 0;
    step();
    armed = 1;
    step();
    rst_i = 0;
    step();

    // Reset mid-operation
    push(32'hA5A5_A5A5, 0);
    step();
    rst_i = 1; step(); rst_i = 0;
    step();

    // Steering
    push(32'h1111_1111, 0);
    push(32'h2222_2222, 1);
    step(2);
    ready0_i = 1; ready1_i = 1; step(); ready0_i = 0; ready1_i = 0;
    step();

    // Full / backpressure
    push(32'h1, 0);
    push(32'h2, 0);
    select_i = 1; step(); select_i = 0; step();
    valid_i = 1; data_i = 32'h3; select_i = 0;
    step(3);
    ready0_i = 1; step(); ready0_i = 0;
    step();
    valid_i = 0;
    step();
    ready0_i = 1; step(3); ready0_i = 0;

    // Simultaneous push/pop on channel 1
    push(32'h5, 1);
    ready1_i = 1; push(32'h6, 1); ready1_i = 0;
    step(2);
    ready1_i = 1; step(); ready1_i = 0;

    // Wrap-around with toggling consumer
    begin
      int i;
      int guard;
      logic acc;
      i = 0; guard = 0;
      while (i < 10 && guard < 100) begin
        valid_i = 1; data_i = SIZE'(i); select_i = 0;
        ready0_i = ~ready0_i;
        @(negedge clk_i);
        acc = ready_o;
        step();
        if (acc) i++;
        guard++;
      end
      chk("wrap_timeout", guard < 100, 1);
      valid_i = 0; ready0_i = 1;
      step(4);
      ready0_i = 0;
    end

    // Independent stall: channel 0 full and stalled, channel 1 draining
    push(32'hC0, 0);
    push(32'hC1, 0);
    ready1_i = 1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) begin
        valid_i = 1; select_i = 1; data_i = 32'h100 + k;
      end else begin
        valid_i = 0; select_i = 0;
      end
      step();
    end
    valid_i = 0;
    step(2);
    ready1_i = 0;
    ready0_i = 1; step(3); ready0_i = 0;
    step();

    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
